hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Parametrised hazard unit for the 5-stage pipeline with a multi-cycle unit (MUL/DIV, MC) beside EXE.
//  Provides: per-source EXE bypass select (MEM/WB/MC-writeback), load-use stall, register scoreboard
//  for in-flight MC results (RAW/WAW stall), MC outstanding-limit stall, branch flush, stall perf counter.
// PARAMETERS
//  ADDR_W        5  register address width; register 0 is hardwired zero, never tracked/bypassed
//  NUM_SRC       2  source operands per instruction (DE and EXE)
//  ALU_SRC_SEL_W 2  bypass select width (fixed encoding below, must be >=2)
//  MAX_MC        4  max in-flight MC ops (>=1)
//  CNT_W        16  stall counter width
// PORTS
//  clk_i          in  1                clock
//  rst_n_i        in  1                async active-low reset
//  rf_src_e_i     in  NUM_SRC*ADDR_W   EXE source regs, src k at [k*ADDR_W +: ADDR_W]
//  rf_dst_m_i     in  ADDR_W           MEM dst;  rf_we_m_i in 1: MEM writes RF
//  rf_dst_w_i     in  ADDR_W           WB dst;   rf_we_w_i in 1: WB writes RF
//  mc_wb_valid_i  in  1                MC result written to RF this cycle
//  mc_wb_dst_i    in  ADDR_W           MC result dst
//  alu_src_sel_o  out NUM_SRC*ALU_SRC_SEL_W  per-source select: 00 RF, 01 WB, 10 MEM, 11 MC-wb
//  rf_src_d_i     in  NUM_SRC*ADDR_W   DE source regs
//  src_used_d_i   in  NUM_SRC          DE source k actually read (0 for imm/unused)
//  rf_dst_d_i     in  ADDR_W           DE dst;   rf_we_d_i in 1: DE writes RF
//  is_mc_d_i      in  1                DE instruction is MC op
//  rf_dst_e_i     in  ADDR_W           EXE dst;  mem2rf_e_i in 1: EXE is load
//  mc_issue_e_i   in  1                EXE MC op handed to MC unit this cycle
//  pc_src_i       in  1                taken branch/jump resolved in MEM
//  latch_en_f_o   out 1                FE/PC latch enable
//  latch_clear_f_o, latch_clear_d_o, latch_clear_e_o  out 1 each  pipeline latch clears
//  mc_pending_o   out 2**ADDR_W        scoreboard bits (debug/verify)
//  mc_count_o     out $clog2(MAX_MC+1) in-flight MC ops
//  stall_cnt_o    out CNT_W            saturating count of stall cycles
// BEHAVIOUR
//  Reset (async, rst_n_i=0): mc_pending_o=0, mc_count_o=0, stall_cnt_o=0; other outputs combinational.
//  Bypass, per src k, src!=0: MEM match&rf_we_m_i -> 10; else MC match&mc_wb_valid_i -> 11;
//   else WB match&rf_we_w_i -> 01; else 00. src==0 -> 00 always.
//  match_k(x): src_used_d_i[k] & rf_src_d_i[k]!=0 & rf_src_d_i[k]==x.
//  Stall terms (combinational, uses current scoreboard, before this cycle's update):
//   load_use = mem2rf_e_i & any_k match_k(rf_dst_e_i)
//   raw_mc   = any_k match_k(r) with mc_pending_o[r]=1 and not (mc_wb_valid_i & mc_wb_dst_i==r)
//   waw_mc   = rf_we_d_i & rf_dst_d_i!=0 & mc_pending_o[rf_dst_d_i] & not same-cycle clear of it
//   mc_full  = is_mc_d_i & (mc_count_o + mc_issue_e_i) >= MAX_MC  (ignore same-cycle retire)
//   stall    = load_use | raw_mc | waw_mc | mc_full
//  Outputs: latch_en_f_o=~stall | pc_src_i; latch_clear_d_o=stall | pc_src_i;
//   latch_clear_f_o=latch_clear_e_o=pc_src_i. Flush dominates stall.
//  Scoreboard, clocked:
//   set   = mc_issue_e_i & ~pc_src_i & rf_dst_e_i!=0 (wrong-path EXE op never recorded)
//   clear = mc_wb_valid_i & mc_wb_dst_i!=0
//   same reg set and clear in one cycle -> bit ends 1 (set wins). Bit 0 never set.
//   mc_count_o += (mc_issue_e_i & ~pc_src_i) - mc_wb_valid_i; issue with count==MAX_MC or
//   retire with count==0 is a protocol error: count saturates at bounds, assertion fires.
//  stall_cnt_o += 1 when stall & ~pc_src_i; holds at 2**CNT_W-1 (no wrap).
//  No latency: all hazard outputs same-cycle; state visible next cycle.
//  MC ops in flight are NOT cancelled by pc_src_i (issued before branch resolved = older, valid).
// TESTING
//  1 EXE src0=5, MEM dst=5 we=1, WB dst=5 we=1 -> sel src0=10; MEM we=0 -> 01; src0=0 -> 00.
//  2 EXE load dst=7, DE src1=7 used -> latch_en_f_o=0, latch_clear_d_o=1, stall_cnt_o 0->1;
//    src_used_d_i[1]=0 -> no stall.
//  3 MC issue dst=9; next cycles DE reads 9 -> stall; mc_wb_valid_i dst=9 -> stall drops same
//    cycle, sel=11 for EXE src 9 in that cycle; mc_pending_o[9] 1->0.
//  4 MAX_MC=2: issue 2 MC ops, DE is_mc -> stall until one retires; mc_count_o 2->1.
//  5 pc_src_i=1 with mc_issue_e_i=1 dst=3 and load-use stall -> all clears=1, latch_en_f_o=1,
//    mc_pending_o[3] stays 0, stall_cnt_o unchanged.
//  6 rst_n_i low mid-stream with pending bits/counter nonzero -> all state 0 immediately (async).

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage pipeline with a multi-cycle unit beside EXE:
// EXE bypass selects, load-use / MC scoreboard stalls, flush control and a stall counter.
module hazard_scoreboard_unit #(
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned NUM_SRC       = 2,
    parameter int unsigned ALU_SRC_SEL_W = 2,
    parameter int unsigned MAX_MC        = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic [NUM_SRC*ADDR_W-1:0]        rf_src_e_i,
    input  logic [ADDR_W-1:0]                rf_dst_m_i,
    input  logic                             rf_we_m_i,
    input  logic [ADDR_W-1:0]                rf_dst_w_i,
    input  logic                             rf_we_w_i,
    input  logic                             mc_wb_valid_i,
    input  logic [ADDR_W-1:0]                mc_wb_dst_i,
    output logic [NUM_SRC*ALU_SRC_SEL_W-1:0] alu_src_sel_o,
    input  logic [NUM_SRC*ADDR_W-1:0]        rf_src_d_i,
    input  logic [NUM_SRC-1:0]               src_used_d_i,
    input  logic [ADDR_W-1:0]                rf_dst_d_i,
    input  logic                             rf_we_d_i,
    input  logic                             is_mc_d_i,
    input  logic [ADDR_W-1:0]                rf_dst_e_i,
    input  logic                             mem2rf_e_i,
    input  logic                             mc_issue_e_i,
    input  logic                             pc_src_i,
    output logic                             latch_en_f_o,
    output logic                             latch_clear_f_o,
    output logic                             latch_clear_d_o,
    output logic                             latch_clear_e_o,
    output logic [2**ADDR_W-1:0]             mc_pending_o,
    output logic [$clog2(MAX_MC+1)-1:0]      mc_count_o,
    output logic [CNT_W-1:0]                 stall_cnt_o
);

    localparam int unsigned NREG     = 2**ADDR_W;
    localparam int unsigned MC_CNT_W = $clog2(MAX_MC+1);
    localparam logic [MC_CNT_W-1:0] MC_LIMIT = MC_CNT_W'(MAX_MC);

    logic            load_use;
    logic            raw_mc;
    logic            waw_mc;
    logic            mc_full;
    logic            stall;
    logic            issue_eff;
    logic [NREG-1:0] pending_nxt;

    // MEM has priority over the MC writeback, which is newer than the WB stage result.
    always_comb begin
        alu_src_sel_o = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (rf_src_e_i[k*ADDR_W +: ADDR_W] != '0) begin
                if (rf_we_m_i && rf_src_e_i[k*ADDR_W +: ADDR_W] == rf_dst_m_i)
                    alu_src_sel_o[k*ALU_SRC_SEL_W +: ALU_SRC_SEL_W] = ALU_SRC_SEL_W'(2);
                else if (mc_wb_valid_i && rf_src_e_i[k*ADDR_W +: ADDR_W] == mc_wb_dst_i)
                    alu_src_sel_o[k*ALU_SRC_SEL_W +: ALU_SRC_SEL_W] = ALU_SRC_SEL_W'(3);
                else if (rf_we_w_i && rf_src_e_i[k*ADDR_W +: ADDR_W] == rf_dst_w_i)
                    alu_src_sel_o[k*ALU_SRC_SEL_W +: ALU_SRC_SEL_W] = ALU_SRC_SEL_W'(1);
            end
        end
    end

    always_comb begin
        load_use = 1'b0;
        raw_mc   = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (src_used_d_i[k] && rf_src_d_i[k*ADDR_W +: ADDR_W] != '0) begin
                if (mem2rf_e_i && rf_src_d_i[k*ADDR_W +: ADDR_W] == rf_dst_e_i)
                    load_use = 1'b1;
                if (mc_pending_o[rf_src_d_i[k*ADDR_W +: ADDR_W]] &&
                    !(mc_wb_valid_i && mc_wb_dst_i == rf_src_d_i[k*ADDR_W +: ADDR_W]))
                    raw_mc = 1'b1;
            end
        end
        waw_mc  = rf_we_d_i && rf_dst_d_i != '0 && mc_pending_o[rf_dst_d_i] &&
                  !(mc_wb_valid_i && mc_wb_dst_i == rf_dst_d_i);
        mc_full = is_mc_d_i && ((32'(mc_count_o) + 32'(mc_issue_e_i)) >= MAX_MC);
        stall   = load_use | raw_mc | waw_mc | mc_full;
    end

    assign latch_en_f_o    = ~stall | pc_src_i;
    assign latch_clear_d_o = stall | pc_src_i;
    assign latch_clear_f_o = pc_src_i;
    assign latch_clear_e_o = pc_src_i;

    // A flushed EXE op is wrong-path and never reaches the MC unit.
    assign issue_eff = mc_issue_e_i & ~pc_src_i;

    // Clear first so a same-cycle set of the same register wins.
    always_comb begin
        pending_nxt = mc_pending_o;
        if (mc_wb_valid_i && mc_wb_dst_i != '0)
            pending_nxt[mc_wb_dst_i] = 1'b0;
        if (issue_eff && rf_dst_e_i != '0)
            pending_nxt[rf_dst_e_i] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mc_pending_o <= '0;
            mc_count_o   <= '0;
            stall_cnt_o  <= '0;
        end else begin
            mc_pending_o <= pending_nxt;
            if (issue_eff && !mc_wb_valid_i) begin
                if (mc_count_o != MC_LIMIT)
                    mc_count_o <= mc_count_o + MC_CNT_W'(1);
            end else if (!issue_eff && mc_wb_valid_i) begin
                if (mc_count_o != '0)
                    mc_count_o <= mc_count_o - MC_CNT_W'(1);
            end
            if (stall && !pc_src_i && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

    mc_count_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(issue_eff && !mc_wb_valid_i && mc_count_o == MC_LIMIT));

    mc_count_underflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(mc_wb_valid_i && !issue_eff && mc_count_o == '0));

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench for hazard_scoreboard_unit (MAX_MC=2, CNT_W=3 to reach the limits quickly).
module tb_hazard_scoreboard_unit;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NSRC   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  rf_src_e = '0;
    logic [4:0]  rf_dst_m = '0;
    logic        rf_we_m = 1'b0;
    logic [4:0]  rf_dst_w = '0;
    logic        rf_we_w = 1'b0;
    logic        mc_wb_valid = 1'b0;
    logic [4:0]  mc_wb_dst = '0;
    logic [3:0]  alu_src_sel;
    logic [9:0]  rf_src_d = '0;
    logic [1:0]  src_used_d = '0;
    logic [4:0]  rf_dst_d = '0;
    logic        rf_we_d = 1'b0;
    logic        is_mc_d = 1'b0;
    logic [4:0]  rf_dst_e = '0;
    logic        mem2rf_e = 1'b0;
    logic        mc_issue_e = 1'b0;
    logic        pc_src = 1'b0;
    logic        latch_en_f, latch_clear_f, latch_clear_d, latch_clear_e;
    logic [31:0] mc_pending;
    logic [1:0]  mc_count;
    logic [2:0]  stall_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        string       tag;
        int unsigned sig;
        logic [31:0] val;
    } exp_t;

    exp_t comb_q[$];
    exp_t state_q[$];

    localparam int unsigned S_SEL = 0, S_EN_F = 1, S_CLR_F = 2, S_CLR_D = 3, S_CLR_E = 4,
                            S_PEND = 5, S_CNT = 6, S_STALL = 7;

    hazard_scoreboard_unit #(
        .ADDR_W(ADDR_W), .NUM_SRC(NSRC), .ALU_SRC_SEL_W(2), .MAX_MC(2), .CNT_W(3)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .rf_src_e_i(rf_src_e), .rf_dst_m_i(rf_dst_m), .rf_we_m_i(rf_we_m),
        .rf_dst_w_i(rf_dst_w), .rf_we_w_i(rf_we_w),
        .mc_wb_valid_i(mc_wb_valid), .mc_wb_dst_i(mc_wb_dst),
        .alu_src_sel_o(alu_src_sel),
        .rf_src_d_i(rf_src_d), .src_used_d_i(src_used_d),
        .rf_dst_d_i(rf_dst_d), .rf_we_d_i(rf_we_d), .is_mc_d_i(is_mc_d),
        .rf_dst_e_i(rf_dst_e), .mem2rf_e_i(mem2rf_e), .mc_issue_e_i(mc_issue_e),
        .pc_src_i(pc_src),
        .latch_en_f_o(latch_en_f), .latch_clear_f_o(latch_clear_f),
        .latch_clear_d_o(latch_clear_d), .latch_clear_e_o(latch_clear_e),
        .mc_pending_o(mc_pending), .mc_count_o(mc_count), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] observe(input int unsigned sig);
        case (sig)
            S_SEL:   return 32'(alu_src_sel);
            S_EN_F:  return 32'(latch_en_f);
            S_CLR_F: return 32'(latch_clear_f);
            S_CLR_D: return 32'(latch_clear_d);
            S_CLR_E: return 32'(latch_clear_e);
            S_PEND:  return mc_pending;
            S_CNT:   return 32'(mc_count);
            default: return 32'(stall_cnt);
        endcase
    endfunction

    task automatic push_c(input string tag, input int unsigned sig, input logic [31:0] val);
        comb_q.push_back('{tag, sig, val});
    endtask

    task automatic push_s(input string tag, input int unsigned sig, input logic [31:0] val);
        state_q.push_back('{tag, sig, val});
    endtask

    task automatic push_state(input string tag, input logic [31:0] pend,
                              input logic [31:0] cnt, input logic [31:0] stl);
        push_s({tag, "_pend"}, S_PEND, pend);
        push_s({tag, "_cnt"}, S_CNT, cnt);
        push_s({tag, "_stall_cnt"}, S_STALL, stl);
    endtask

    task automatic drain(inout exp_t q[$]);
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            check_eq(e.tag, observe(e.sig), e.val);
        end
    endtask

    task automatic start_cycle();
        @(negedge clk);
        rf_src_e = '0; rf_dst_m = '0; rf_we_m = 1'b0; rf_dst_w = '0; rf_we_w = 1'b0;
        mc_wb_valid = 1'b0; mc_wb_dst = '0; rf_src_d = '0; src_used_d = '0;
        rf_dst_d = '0; rf_we_d = 1'b0; is_mc_d = 1'b0; rf_dst_e = '0;
        mem2rf_e = 1'b0; mc_issue_e = 1'b0; pc_src = 1'b0;
    endtask

    task automatic end_cycle();
        #1 drain(comb_q);
        @(posedge clk);
        #1 drain(state_q);
    endtask

    initial begin
        #12 rst_n = 1'b1;
        push_c("rst_pend", S_PEND, 0);
        push_c("rst_cnt", S_CNT, 0);
        push_c("rst_stall_cnt", S_STALL, 0);
        drain(comb_q);

        // bypass priority
        start_cycle();
        rf_src_e = {5'd5, 5'd5}; rf_dst_m = 5'd5; rf_we_m = 1'b1; rf_dst_w = 5'd5; rf_we_w = 1'b1;
        push_c("byp_mem", S_SEL, 32'b1010);
        push_c("byp_mem_en", S_EN_F, 1);
        end_cycle();
        start_cycle();
        rf_src_e = {5'd5, 5'd5}; rf_dst_m = 5'd5; rf_dst_w = 5'd5; rf_we_w = 1'b1;
        push_c("byp_wb", S_SEL, 32'b0101);
        end_cycle();
        start_cycle();
        rf_dst_m = 5'd0; rf_we_m = 1'b1; rf_dst_w = 5'd0; rf_we_w = 1'b1;
        push_c("byp_r0", S_SEL, 0);
        end_cycle();

        // load-use
        start_cycle();
        mem2rf_e = 1'b1; rf_dst_e = 5'd7; rf_src_d = {5'd7, 5'd0}; src_used_d = 2'b10;
        push_c("lu_en", S_EN_F, 0);
        push_c("lu_clr_d", S_CLR_D, 1);
        push_c("lu_clr_f", S_CLR_F, 0);
        push_s("lu_stall_cnt", S_STALL, 1);
        end_cycle();
        start_cycle();
        mem2rf_e = 1'b1; rf_dst_e = 5'd7; rf_src_d = {5'd7, 5'd0}; src_used_d = 2'b00;
        push_c("lu_unused_en", S_EN_F, 1);
        push_c("lu_unused_clr_d", S_CLR_D, 0);
        push_s("lu_unused_stall_cnt", S_STALL, 1);
        end_cycle();

        // MC RAW / WAW against scoreboard
        start_cycle();
        mc_issue_e = 1'b1; rf_dst_e = 5'd9;
        push_c("mci_en", S_EN_F, 1);
        push_state("mci", 32'h200, 1, 1);
        end_cycle();
        start_cycle();
        rf_src_d = {5'd0, 5'd9}; src_used_d = 2'b01;
        push_c("raw_en", S_EN_F, 0);
        push_state("raw", 32'h200, 1, 2);
        end_cycle();
        start_cycle();
        rf_we_d = 1'b1; rf_dst_d = 5'd9;
        push_c("waw_clr_d", S_CLR_D, 1);
        push_state("waw", 32'h200, 1, 3);
        end_cycle();
        start_cycle();
        rf_src_d = {5'd0, 5'd9}; src_used_d = 2'b01;
        mc_wb_valid = 1'b1; mc_wb_dst = 5'd9; rf_src_e = {5'd0, 5'd9};
        push_c("mcwb_en", S_EN_F, 1);
        push_c("mcwb_sel", S_SEL, 32'b0011);
        push_state("mcwb", 0, 0, 3);
        end_cycle();

        // outstanding limit
        start_cycle();
        mc_issue_e = 1'b1; rf_dst_e = 5'd10; is_mc_d = 1'b1;
        push_c("lim0_en", S_EN_F, 1);
        push_state("lim0", 32'h400, 1, 3);
        end_cycle();
        start_cycle();
        mc_issue_e = 1'b1; rf_dst_e = 5'd11; is_mc_d = 1'b1;
        push_c("lim1_en", S_EN_F, 0);
        push_state("lim1", 32'hC00, 2, 4);
        end_cycle();
        start_cycle();
        is_mc_d = 1'b1;
        push_c("full_en", S_EN_F, 0);
        push_state("full", 32'hC00, 2, 5);
        end_cycle();
        start_cycle();
        is_mc_d = 1'b1; mc_wb_valid = 1'b1; mc_wb_dst = 5'd10;
        push_c("full_ret_en", S_EN_F, 0);
        push_state("full_ret", 32'h800, 1, 6);
        end_cycle();
        start_cycle();
        is_mc_d = 1'b1;
        push_c("below_en", S_EN_F, 1);
        push_state("below", 32'h800, 1, 6);
        end_cycle();
        start_cycle();
        mc_wb_valid = 1'b1; mc_wb_dst = 5'd11;
        push_state("drain", 0, 0, 6);
        end_cycle();

        // flush dominates stall, wrong-path issue dropped
        start_cycle();
        pc_src = 1'b1; mc_issue_e = 1'b1; rf_dst_e = 5'd3; mem2rf_e = 1'b1;
        rf_src_d = {5'd0, 5'd3}; src_used_d = 2'b01;
        push_c("fl_en", S_EN_F, 1);
        push_c("fl_clr_f", S_CLR_F, 1);
        push_c("fl_clr_d", S_CLR_D, 1);
        push_c("fl_clr_e", S_CLR_E, 1);
        push_state("fl", 0, 0, 6);
        end_cycle();

        // stall counter saturation
        for (int i = 0; i < 2; i++) begin
            start_cycle();
            mem2rf_e = 1'b1; rf_dst_e = 5'd4; rf_src_d = {5'd4, 5'd0}; src_used_d = 2'b10;
            push_s("sat_stall_cnt", S_STALL, 7);
            end_cycle();
        end

        // async reset mid-cycle
        start_cycle();
        mc_issue_e = 1'b1; rf_dst_e = 5'd12;
        push_state("pre_rst", 32'h1000, 1, 7);
        end_cycle();
        @(negedge clk);
        mc_issue_e = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        push_c("arst_pend", S_PEND, 0);
        push_c("arst_cnt", S_CNT, 0);
        push_c("arst_stall_cnt", S_STALL, 0);
        drain(comb_q);
        #4 rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
